key_sw_conditioner: RTL and testbench



---
 rtl/key_sw_conditioner_if.sv | 22 ++
 rtl/key_sw_conditioner.sv | 52 +++++
 tb/tb_key_sw_conditioner.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/key_sw_conditioner_if.sv
// key_sw_conditioner_if: raw pins, sticky-clear strobes and conditioned key/switch outputs
interface key_sw_conditioner_if #(
  parameter int NKEYS = 4,
  parameter int NSW   = 10
);
  logic [NKEYS-1:0] key_raw;
  logic [NKEYS-1:0] key_clr;
  logic [NKEYS-1:0] key_out;
  logic [NKEYS-1:0] key_press;
  logic [NKEYS-1:0] key_sticky;
  logic [NSW-1:0]   sw_raw;
  logic [NSW-1:0]   sw_out;
  logic             sw_changed;
  modport master (
    output key_raw, sw_raw, key_clr,
    input  key_out, key_press, key_sticky, sw_out, sw_changed
  );
  modport slave (
    input  key_raw, sw_raw, key_clr,
    output key_out, key_press, key_sticky, sw_out, sw_changed
  );
endinterface

// File: rtl/key_sw_conditioner.sv
// key_sw_conditioner: synchronise, debounce and edge-detect board keys and switches
module key_sw_conditioner #(
  parameter int NKEYS           = 4,
  parameter int NSW             = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input logic clk,
  input logic reset,
  key_sw_conditioner_if.slave bus
);
  localparam int N  = NKEYS + NSW;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [N-1:0]     w_pin, r_s1, r_s2, r_st, r_prev;
  logic [CW-1:0]    r_cnt [N];
  logic [NKEYS-1:0] r_press, r_sticky;
  logic             r_sw_chg;
  // keys are normalised to active-high before entering the synchroniser
  assign w_pin = {bus.sw_raw, bus.key_raw ^ {NKEYS{KEY_ACTIVE_LOW}}};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_st     <= '0;
      r_prev   <= '0;
      r_press  <= '0;
      r_sticky <= '0;
      r_sw_chg <= 1'b0;
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      r_s1     <= w_pin;
      r_s2     <= r_s1;
      r_prev   <= r_st;
      r_press  <= r_st[NKEYS-1:0] & ~r_prev[NKEYS-1:0];
      r_sticky <= r_press | (r_sticky & ~bus.key_clr);
      r_sw_chg <= |(r_st[N-1:NKEYS] ^ r_prev[N-1:NKEYS]);
      for (int i = 0; i < N; i++) begin
        if (r_s2[i] == r_st[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == LAST) begin
          r_st[i]  <= r_s2[i];
          r_cnt[i] <= '0;
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end
  assign bus.key_out    = r_st[NKEYS-1:0];
  assign bus.key_press  = r_press;
  assign bus.key_sticky = r_sticky;
  assign bus.sw_out     = r_st[N-1:NKEYS];
  assign bus.sw_changed = r_sw_chg;
endmodule

// File: tb/tb_key_sw_conditioner.sv
// tb_key_sw_conditioner: directed and random stimulus checked against a window-based debounce model
module tb_key_sw_conditioner;
  localparam int K = 4;
  localparam int S = 10;
  localparam int D = 4;
  localparam int N = K + S;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  key_sw_conditioner_if #(.NKEYS(K), .NSW(S)) bus ();
  key_sw_conditioner #(.NKEYS(K), .NSW(S), .DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  // model: a bit flips once its last D synchronised samples all disagree with the stable level
  logic [N-1:0] m_s1, m_s2, m_st, m_prev;
  logic [D-1:0] m_h [N];
  logic [K-1:0] m_press, m_sticky;
  logic         m_chg;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_st = '0; m_prev = '0;
    m_press = '0; m_sticky = '0; m_chg = 1'b0;
    for (int i = 0; i < N; i++) m_h[i] = '0;
  endtask
  task automatic tick();
    logic [N-1:0] pin, nst;
    pin = {bus.sw_raw, ~bus.key_raw};
    @(posedge clk);
    if (reset) model_clear();
    else begin
      for (int i = 0; i < N; i++) begin
        m_h[i] = {m_h[i][D-2:0], m_s2[i]};
        nst[i] = (m_h[i] == {D{~m_st[i]}}) ? ~m_st[i] : m_st[i];
      end
      m_sticky = m_press | (m_sticky & ~bus.key_clr);
      m_press  = m_st[K-1:0] & ~m_prev[K-1:0];
      m_chg    = |(m_st[N-1:K] ^ m_prev[N-1:K]);
      m_prev   = m_st;
      m_st     = nst;
      m_s2     = m_s1;
      m_s1     = pin;
    end
    #1;
    chk("key_out", 32'(bus.key_out), 32'(m_st[K-1:0]));
    chk("key_press", 32'(bus.key_press), 32'(m_press));
    chk("key_sticky", 32'(bus.key_sticky), 32'(m_sticky));
    chk("sw_out", 32'(bus.sw_out), 32'(m_st[N-1:K]));
    chk("sw_changed", 32'(bus.sw_changed), 32'(m_chg));
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    int presses;
    bit found;
    model_clear();
    bus.key_raw = 4'hF;
    bus.sw_raw  = '0;
    bus.key_clr = '0;
    // reset with keys released
    ticks(3);
    chk("reset_outputs", {bus.key_out, bus.key_press, bus.key_sticky, bus.sw_out, bus.sw_changed}, 32'd0);
    reset = 1'b0;
    ticks(5);
    chk("idle_outputs", {bus.key_out, bus.key_press, bus.key_sticky, bus.sw_out, bus.sw_changed}, 32'd0);
    // clean press on key 0
    bus.key_raw[0] = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      tick();
      chk("key0_latency", 32'(bus.key_out[0]), 32'(n == 6));
    end
    tick();
    chk("key0_press", 32'(bus.key_press[0]), 32'd1);
    tick();
    chk("key0_press_end", 32'(bus.key_press[0]), 32'd0);
    chk("key0_sticky", 32'(bus.key_sticky[0]), 32'd1);
    ticks(4);
    chk("key0_sticky_hold", 32'(bus.key_sticky[0]), 32'd1);
    // bouncing key 1: low runs of 3 separated by single high cycles
    presses = 0;
    for (int r = 0; r < 3; r++) begin
      bus.key_raw[1] = 1'b0;
      for (int j = 0; j < 3; j++) begin tick(); presses += int'(bus.key_press[1]); end
      bus.key_raw[1] = 1'b1;
      tick(); presses += int'(bus.key_press[1]);
      chk("key1_bounce_out", 32'(bus.key_out[1]), 32'd0);
    end
    bus.key_raw[1] = 1'b0;
    for (int j = 0; j < 12; j++) begin tick(); presses += int'(bus.key_press[1]); end
    chk("key1_out", 32'(bus.key_out[1]), 32'd1);
    chk("key1_press_count", 32'(presses), 32'd1);
    // sticky set/clear collision on key 2
    bus.key_raw[2] = 1'b0;
    ticks(9);
    chk("key2_sticky_first", 32'(bus.key_sticky[2]), 32'd1);
    bus.key_raw[2] = 1'b1;
    ticks(8);
    chk("key2_released", 32'(bus.key_out[2]), 32'd0);
    bus.key_raw[2] = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 20 && !found; j++) begin
      tick();
      found = bus.key_press[2];
    end
    chk("key2_press_seen", 32'(found), 32'd1);
    bus.key_clr = 4'b0100;
    tick();
    bus.key_clr = '0;
    chk("key2_set_wins", 32'(bus.key_sticky[2]), 32'd1);
    ticks(2);
    bus.key_clr = 4'b0100;
    tick();
    bus.key_clr = '0;
    chk("key2_cleared", 32'(bus.key_sticky[2]), 32'd0);
    tick();
    // switches change together
    bus.sw_raw = 10'h201;
    for (int n = 1; n <= 6; n++) begin
      tick();
      chk("sw_latency", 32'(bus.sw_out), (n == 6) ? 32'h201 : 32'h0);
    end
    tick();
    chk("sw_changed_pulse", 32'(bus.sw_changed), 32'd1);
    tick();
    chk("sw_changed_end", 32'(bus.sw_changed), 32'd0);
    // one-cycle reset while key 0 is held
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_key_out", 32'(bus.key_out), 32'd0);
    chk("rst_sticky", 32'(bus.key_sticky), 32'd0);
    presses = 0;
    for (int n = 1; n <= 6; n++) begin
      tick();
      chk("rst_key0_latency", 32'(bus.key_out[0]), 32'(n == 6));
      presses += int'(bus.key_press[0]);
    end
    for (int j = 0; j < 6; j++) begin tick(); presses += int'(bus.key_press[0]); end
    chk("rst_key0_press_count", 32'(presses), 32'd1);
    // random traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(5) == 0) bus.key_raw = 4'($urandom);
      if ($urandom_range(7) == 0) bus.sw_raw = 10'($urandom);
      bus.key_clr = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      reset = ($urandom_range(99) == 0);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
